// File: rtl/gpu_mem_arbiter.sv
// gpu_mem_arbiter: N_REQ requesters share one single-port tile memory.
// An IDLE cycle picks a winner, whose burst then owns the port for
// burst_len+1 cycles, one beat per cycle.
// Build option: define GPU_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins). Without it, arbitration is round-robin starting after the
// last owner.

// Per-requester handshake: beat_ack while owning, rvalid one cycle after a read beat
module gpu_mem_arb_lane (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic gnt_bit,
  input  logic busy,
  input  logic rd_beat,
  output logic beat_ack,
  output logic rvalid
);
  assign beat_ack = gnt_bit & busy;

  // read return strobe trails the issued beat by the memory latency
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rvalid <= 1'b0;
    else          rvalid <= beat_ack & rd_beat;
  end
endmodule

module gpu_mem_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0]              we,
  input  logic [N_REQ-1:0][7:0]         burst_len,
  input  logic [N_REQ-1:0][ADDR_W-1:0]  start_addr,
  input  logic [N_REQ-1:0][DATA_W-1:0]  wdata,
  output logic [N_REQ-1:0]              gnt,
  output logic [N_REQ-1:0]              beat_ack,
  output logic [N_REQ-1:0]              rvalid,
  output logic [DATA_W-1:0]             rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy
);
  localparam int OW     = $clog2(N_REQ);
  localparam int STAGES = 1;  // memory read latency

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    gnt_q;
  logic [OW-1:0]       owner_q, win_idx;
  logic                win_found, load, done;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          cnt_q;
  logic [STAGES:0]     vld_pipe;
`ifndef GPU_ARB_FIXED_PRIO_EN
  logic [OW-1:0]       last_owner;
`endif

  // winner selection among the live requests
  always_comb begin
`ifdef GPU_ARB_FIXED_PRIO_EN
    win_found = |req;
    win_idx   = '0;
    for (int i = N_REQ-1; i >= 0; i--)
      if (req[i]) win_idx = OW'(i);
`else
    int k;
    win_found = 1'b0;
    win_idx   = '0;
    k         = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      k = (int'(last_owner) + i) % N_REQ;
      if (!win_found && req[k]) begin
        win_found = 1'b1;
        win_idx   = OW'(k);
      end
    end
`endif
  end

  // next-state: IDLE arbitrates, BURST runs until the zero-count beat
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (win_found) begin
        state_d = BURST;
        load    = 1'b1;
      end
      BURST: if (cnt_q == 8'd0) begin
        state_d = IDLE;
        done    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // burst context is latched at grant; requester inputs are ignored after that
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        gnt_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
        owner_q <= win_idx;
        we_q    <= we[win_idx];
        addr_q  <= start_addr[win_idx];
        cnt_q   <= burst_len[win_idx];
      end else if (state_q == BURST) begin
        addr_q <= addr_q + ADDR_W'(1);
        cnt_q  <= cnt_q - 8'd1;
        if (done) gnt_q <= '0;
      end
    end
  end

`ifndef GPU_ARB_FIXED_PRIO_EN
  // round-robin pointer; reset value makes requester 0 win first
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)  last_owner <= OW'(N_REQ-1);
    else if (done) last_owner <= owner_q;
  end
`endif

  // read-valid pipeline aligns rdata gating with mem_rdata
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) vld_pipe[STAGES:1] <= '0;
    else          vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  assign busy        = (state_q == BURST);
  assign gnt         = gnt_q;
  assign mem_en      = busy;
  assign mem_we      = busy & we_q;
  assign mem_addr    = busy ? addr_q : '0;
  assign mem_wdata   = busy ? wdata[owner_q] : '0;
  assign vld_pipe[0] = busy & ~we_q;
  assign rdata       = vld_pipe[STAGES] ? mem_rdata : '0;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    gpu_mem_arb_lane u_lane (
      .ACLK     (ACLK),
      .ARESETN  (ARESETN),
      .gnt_bit  (gnt_q[i]),
      .busy     (busy),
      .rd_beat  (~we_q),
      .beat_ack (beat_ack[i]),
      .rvalid   (rvalid[i])
    );
  end
endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Directed bench for gpu_mem_arbiter with a 1-cycle-latency memory model.
// A table of single bursts plus hand sequences for contention, reset
// mid-burst and arbitration pointer reset.
module tb_gpu_mem_arbiter;
  localparam int N  = 2;
  localparam int AW = 10;
  localparam int DW = 32;

  logic                  ACLK, ARESETN;
  logic [N-1:0]          req, we;
  logic [N-1:0][7:0]     burst_len;
  logic [N-1:0][AW-1:0]  start_addr;
  logic [N-1:0][DW-1:0]  wdata;
  logic [N-1:0]          gnt, beat_ack, rvalid;
  logic [DW-1:0]         rdata, mem_wdata, mem_rdata;
  logic                  mem_en, mem_we, busy;
  logic [AW-1:0]         mem_addr;

  int n_chk = 0;
  int n_fail = 0;

  gpu_mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .req(req), .we(we), .burst_len(burst_len),
    .start_addr(start_addr), .wdata(wdata), .gnt(gnt), .beat_ack(beat_ack),
    .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // memory model: synchronous write, registered read
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge ACLK) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int         idx;
    logic       w;
    logic [9:0] addr;
    logic [7:0] len;
    logic [31:0] dbase;
    int         drop;
    logic [9:0] last_addr;
  } vec_t;

  // wait for a grant, then check every beat and the trailing IDLE cycle
  task automatic run_burst(input vec_t v);
    logic got;
    logic [N-1:0] oh;
    oh = '0;
    oh[v.idx] = 1'b1;
    req[v.idx] = 1'b1; we[v.idx] = v.w; start_addr[v.idx] = v.addr;
    burst_len[v.idx] = v.len; wdata[v.idx] = v.dbase;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge ACLK); #1;
      if (gnt != '0) got = 1'b1;
    end
    chk("grant_seen", 32'(got), 32'd1);
    chk("gnt_owner", 32'(gnt), 32'(oh));
    for (int j = 0; j <= int'(v.len); j++) begin
      wdata[v.idx] = v.dbase + 32'(j);
      if (j == v.drop) req[v.idx] = 1'b0;
      if (j == 1) begin
        start_addr[v.idx] = ~v.addr; burst_len[v.idx] = 8'hFF; we[v.idx] = ~v.w;
      end
      #1;
      chk("mem_en", 32'(mem_en), 32'd1);
      chk("mem_we", 32'(mem_we), 32'(v.w));
      chk("mem_addr", 32'(mem_addr), 32'((v.addr + 10'(j)) & 10'h3FF));
      chk("beat_ack", 32'(beat_ack), 32'(oh));
      if (v.w) chk("mem_wdata", mem_wdata, v.dbase + 32'(j));
      if (j == int'(v.len)) chk("last_addr", 32'(mem_addr), 32'(v.last_addr));
      if (v.w || j == 0) chk("rvalid_quiet", 32'(rvalid), 32'd0);
      else begin
        chk("rvalid", 32'(rvalid), 32'(oh));
        chk("rdata", rdata, v.dbase + 32'(j - 1));
      end
      @(negedge ACLK); #1;
    end
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_gnt", 32'(gnt), 32'd0);
    chk("idle_mem_en", 32'(mem_en), 32'd0);
    if (v.w) chk("idle_rvalid", 32'(rvalid), 32'd0);
    else begin
      chk("final_rvalid", 32'(rvalid), 32'(oh));
      chk("final_rdata", rdata, v.dbase + 32'(v.len));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_beat_ack"}, 32'(beat_ack), 32'd0);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  vec_t vt [7];

  initial begin
    vt[0] = '{0, 1'b1, 10'h010, 8'd7, 32'd1,     0, 10'h017};
    vt[1] = '{0, 1'b0, 10'h010, 8'd7, 32'd1,     0, 10'h017};
    vt[2] = '{1, 1'b1, 10'h3FE, 8'd3, 32'h100,   0, 10'h001};
    vt[3] = '{1, 1'b0, 10'h3FE, 8'd3, 32'h100,   0, 10'h001};
    vt[4] = '{0, 1'b1, 10'h200, 8'd0, 32'hAA,    0, 10'h200};
    vt[5] = '{1, 1'b0, 10'h200, 8'd0, 32'hAA,    0, 10'h200};
    vt[6] = '{1, 1'b1, 10'h040, 8'd5, 32'h50,    2, 10'h045};

    ARESETN = 1'b0; req = '0; we = '0; burst_len = '0; start_addr = '0; wdata = '0;
    repeat (2) @(negedge ACLK);
    #1 chk_all_zero("reset");
    req[0] = 1'b1;  // requests are ignored while held in reset
    @(negedge ACLK); #1;
    chk("reset_hold_gnt", 32'(gnt), 32'd0);
    req = '0;
    ARESETN = 1'b1;

    for (int i = 0; i < 7; i++) run_burst(vt[i]);

    // contention: both held, 4-beat writes; last owner was 1 so 0 goes first
    req = 2'b11; we = 2'b11; burst_len[0] = 8'd3; burst_len[1] = 8'd3;
    start_addr[0] = 10'h100; start_addr[1] = 10'h180;
    for (int k = 0; k < 20; k++) begin
      logic [N-1:0] exp_g;
      int own;
      @(negedge ACLK); #1;
`ifdef GPU_ARB_FIXED_PRIO_EN
      own = 0;
`else
      own = (k / 5) % 2;
`endif
      exp_g = '0;
      if (k % 5 != 4 && k < 19) exp_g[own] = 1'b1;
      chk("contend_gnt", 32'(gnt), 32'(exp_g));
      chk("contend_ack", 32'(beat_ack), 32'(exp_g));
      if (k == 18) req = '0;
    end
    @(negedge ACLK); #1;
    chk("contend_done_busy", 32'(busy), 32'd0);

    // reset during beat 3 of an 8-beat write
    req[0] = 1'b1; we[0] = 1'b1; start_addr[0] = 10'h080; burst_len[0] = 8'd7; wdata[0] = 32'h77;
    begin
      logic got;
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
        @(negedge ACLK); #1;
        if (gnt != '0) got = 1'b1;
      end
      chk("rst_burst_grant", 32'(gnt), 32'd1);
    end
    repeat (2) @(negedge ACLK);
    chk("rst_beat3_addr", 32'(mem_addr), 32'h082);
    ARESETN = 1'b0; req[0] = 1'b0;
    #1 chk_all_zero("midrst");
    @(negedge ACLK); #1;
    chk("midrst_hold_ack", 32'(beat_ack), 32'd0);
    chk("midrst_hold_rvalid", 32'(rvalid), 32'd0);
    ARESETN = 1'b1;
    run_burst('{1, 1'b1, 10'h0C0, 8'd2, 32'h300, 0, 10'h0C2});

    // pointer reset: make 0 the last owner, reset, then both request
    run_burst('{0, 1'b1, 10'h0D0, 8'd0, 32'h400, 0, 10'h0D0});
    ARESETN = 1'b0;
    #2 ARESETN = 1'b1;
    req = 2'b11; we = 2'b11; burst_len[0] = 8'd0; burst_len[1] = 8'd0;
    begin
      logic got;
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
        @(negedge ACLK); #1;
        if (gnt != '0) got = 1'b1;
      end
      req = '0;
      chk("post_reset_first_gnt", 32'(gnt), 32'd1);
    end
    repeat (3) @(negedge ACLK);
    #1 chk("final_idle_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gpu_mem_arbiter.md
GPU_MEM_ARBITER -- requirements
Module: gpu_mem_arbiter

Interface
REQ-001 Parameter N_REQ, default 2, number of requesters sharing the tile memory port (legal 2..4).
REQ-002 Parameter ADDR_W, default 10, memory word-address width.
REQ-003 Parameter DATA_W, default 32, memory data width.
REQ-004 ACLK  input  1  single clock; all logic on rising edge.
REQ-005 ARESETN  input  1  asynchronous active-low reset.
REQ-006 req  input  N_REQ  per-requester burst request, level.
REQ-007 we  input  N_REQ  per-requester direction: 1 write, 0 read.
REQ-008 burst_len  input  N_REQ*8  per-requester beats minus one (0..255).
REQ-009 start_addr  input  N_REQ*ADDR_W  per-requester first word address.
REQ-010 wdata  input  N_REQ*DATA_W  per-requester current write beat.
REQ-011 gnt  output  N_REQ  one-hot burst ownership.
REQ-012 beat_ack  output  N_REQ  one-cycle pulse: current beat issued to memory.
REQ-013 rvalid  output  N_REQ  one-cycle pulse: rdata holds a read beat for that requester.
REQ-014 rdata  output  DATA_W  read data to requesters.
REQ-015 mem_en, mem_we  output  1 each  memory port strobes.
REQ-016 mem_addr  output  ADDR_W  memory address.
REQ-017 mem_wdata  output  DATA_W  memory write data.
REQ-018 mem_rdata  input  DATA_W  memory read data, valid 1 cycle after mem_en with mem_we=0.
REQ-019 busy  output  1  high while in BURST.

Function
REQ-020 FSM states IDLE and BURST only.
REQ-021 IDLE: if any req bit high, select one winner, register gnt, owner index, we, start_addr and burst_len into beat counter, go to BURST next cycle; otherwise stay.
REQ-022 Default selection is round-robin: search starts at index last_owner+1 mod N_REQ; last_owner resets to N_REQ-1 so index 0 wins first.
REQ-023 BURST: every cycle mem_en=1, mem_we=latched we, mem_addr=current address, mem_wdata=wdata slice of owner (combinational), beat_ack[owner]=1.
REQ-024 Address increments by 1 per beat, wrapping modulo 2^ADDR_W (0x3FF -> 0x000 at default).
REQ-025 Beat counter decrements per beat; beat issued with counter 0 is last; next cycle FSM is IDLE, gnt cleared, last_owner updated to owner.
REQ-026 Burst of burst_len=L occupies exactly L+1 cycles in BURST; one IDLE arbitration cycle separates consecutive bursts.
REQ-027 req is sampled only in IDLE; deasserting req mid-burst does not shorten the burst; req/burst_len/start_addr/we changes mid-burst are ignored.
REQ-028 Read beats: rvalid[owner] asserted one cycle after each read beat, rdata = mem_rdata; the final read rvalid may coincide with the IDLE cycle and with a new grant.
REQ-029 Write beats never assert rvalid.
REQ-030 gnt, busy, beat_ack and mem_en are mutually consistent: at most one gnt bit; beat_ack only to gnt holder.

Reset
REQ-031 ARESETN low asynchronously forces: state IDLE, gnt=0, beat_ack=0, rvalid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, busy=0, last_owner=N_REQ-1.
REQ-032 Reset mid-burst abandons the burst; no beat_ack or rvalid after reset assertion; first arbitration after release follows REQ-022.

Configuration
REQ-033 Macro GPU_ARB_FIXED_PRIO_EN: when defined, selection is fixed priority, lowest index wins, last_owner unused; when undefined, round-robin per REQ-022.

Verification
REQ-034 Single write: req[0]=1, we=1, start_addr=0x010, burst_len=7, wdata=1..8 -> 8 consecutive mem_en cycles, mem_addr 0x010..0x017, mem_wdata 1..8, 8 beat_ack[0] pulses, no rvalid.
REQ-035 Read back: req[0] read, start_addr=0x010, burst_len=7, memory model 1-cycle -> rvalid[0] 8 pulses, rdata 1..8, each 1 cycle after its beat.
REQ-036 Contention: req[0] and req[1] both held, burst_len=3 each -> grants alternate 0,1,0,1 with 4-cycle bursts and one IDLE cycle between; with GPU_ARB_FIXED_PRIO_EN, requester 0 granted every time.
REQ-037 Wrap: start_addr=0x3FE, burst_len=3 -> mem_addr 0x3FE,0x3FF,0x000,0x001.
REQ-038 Early drop: req[1] deasserted after 2nd beat of burst_len=5 -> all 6 beats still issued.
REQ-039 Reset mid-burst: ARESETN low during beat 3 of 8 -> all outputs zero immediately; after release with req[1] only, gnt[1] next-but-one cycle, addresses restart at start_addr.
